// File: rtl/amo_shim_lrsc.sv
// Atomic shim for one TCDM bank: RISC-V AMOs on a 32-bit lane of the SRAM
// word, plus LR/SC backed by a per-requester row reservation table.
module amo_shim_lrsc #(
   parameter int unsigned AddrMemWidth = 32,
   parameter int unsigned DataWidth    = 64,
   parameter int unsigned NumIds       = 8,
   parameter int unsigned IdWidth      = (NumIds > 1) ? $clog2(NumIds) : 1
) (
   input  logic                      clk_i,
   input  logic                      rst_ni,
   input  logic                      in_req_i,
   output logic                      in_gnt_o,
   input  logic [AddrMemWidth-1:0]   in_add_i,
   input  logic [3:0]                in_amo_i,
   input  logic                      in_wen_i,
   input  logic [DataWidth-1:0]      in_wdata_i,
   input  logic [DataWidth/8-1:0]    in_be_i,
   input  logic [IdWidth-1:0]        in_id_i,
   output logic [DataWidth-1:0]      in_rdata_o,
   output logic                      in_rvalid_o,
   output logic                      out_req_o,
   output logic [AddrMemWidth-1:0]   out_add_o,
   output logic                      out_wen_o,
   output logic [DataWidth-1:0]      out_wdata_o,
   output logic [DataWidth/8-1:0]    out_be_o,
   input  logic [DataWidth-1:0]      out_rdata_i
);

   localparam int NumLanes = int'(DataWidth / 32);
   localparam int LaneW    = (NumLanes > 1) ? $clog2(NumLanes) : 1;

   localparam logic [3:0] AmoNone = 4'h0;
   localparam logic [3:0] AmoSwap = 4'h1;
   localparam logic [3:0] AmoAdd  = 4'h2;
   localparam logic [3:0] AmoAnd  = 4'h3;
   localparam logic [3:0] AmoOr   = 4'h4;
   localparam logic [3:0] AmoXor  = 4'h5;
   localparam logic [3:0] AmoMax  = 4'h6;
   localparam logic [3:0] AmoMaxu = 4'h7;
   localparam logic [3:0] AmoMin  = 4'h8;
   localparam logic [3:0] AmoMinu = 4'h9;
   localparam logic [3:0] AmoCas  = 4'hA;
   localparam logic [3:0] AmoLr   = 4'hB;
   localparam logic [3:0] AmoSc   = 4'hC;

   typedef enum logic {Idle, DoAmo} state_e;

   state_e                  state_q, state_d;
   logic [3:0]              amo_q, amo_d;
   logic [AddrMemWidth-1:0] addr_q, addr_d;
   logic [LaneW-1:0]        sel_q, sel_d;
   logic [31:0]             opb_q, opb_d;
   logic [31:0]             swap_q, swap_d;
   logic                    rvalid_q, rvalid_d;
   logic                    sc_q, sc_d;
   logic                    sc_fail_q, sc_fail_d;
   logic [NumIds-1:0]       res_valid_q, res_valid_d;
   logic [AddrMemWidth-1:0] res_addr_q [NumIds];
   logic [AddrMemWidth-1:0] res_addr_d [NumIds];

   logic [LaneW-1:0] sel;
   logic [31:0]      opb, swp, old, result;
   logic [32:0]      a_ext, b_ext, diff;
   logic             is_amo, is_lr, is_sc, is_plain, sc_ok, signed_op, lt;

   assign is_amo   = (in_amo_i >= AmoSwap) && (in_amo_i <= AmoCas);
   assign is_lr    = (in_amo_i == AmoLr);
   assign is_sc    = (in_amo_i == AmoSc);
   assign is_plain = !is_amo && !is_lr && !is_sc;
   assign sc_ok    = res_valid_q[in_id_i] && (res_addr_q[in_id_i] == in_add_i);

   // Lowest lane with any byte enabled wins; CAS swap value is the next lane up.
   always_comb begin
      sel = '0;
      opb = in_wdata_i[31:0];
      swp = in_wdata_i[32*(1 % NumLanes) +: 32];
      for (int l = NumLanes - 1; l >= 0; l--) begin
         if (|in_be_i[4*l +: 4]) begin
            sel = LaneW'(l);
            opb = in_wdata_i[32*l +: 32];
            swp = in_wdata_i[32*((l + 1) % NumLanes) +: 32];
         end
      end
   end

   always_comb begin
      old = out_rdata_i[31:0];
      for (int l = 0; l < NumLanes; l++) begin
         if (sel_q == LaneW'(l)) old = out_rdata_i[32*l +: 32];
      end
   end

   assign signed_op = (amo_q == AmoMax) || (amo_q == AmoMin);
   assign a_ext     = {signed_op & old[31], old};
   assign b_ext     = {signed_op & opb_q[31], opb_q};
   assign diff      = a_ext - b_ext;
   assign lt        = diff[32];

   always_comb begin
      result = old;
      case (amo_q)
         AmoSwap: result = opb_q;
         AmoAdd:  result = old + opb_q;
         AmoAnd:  result = old & opb_q;
         AmoOr:   result = old | opb_q;
         AmoXor:  result = old ^ opb_q;
         AmoMax,
         AmoMaxu: result = lt ? opb_q : old;
         AmoMin,
         AmoMinu: result = lt ? old : opb_q;
         AmoCas:  result = (old == opb_q) ? swap_q : old;
         default: result = old;
      endcase
   end

   always_comb begin
      in_gnt_o    = 1'b0;
      out_req_o   = in_req_i;
      out_add_o   = in_add_i;
      out_wen_o   = in_wen_i;
      out_wdata_o = in_wdata_i;
      out_be_o    = in_be_i;
      state_d     = state_q;
      amo_d       = amo_q;
      addr_d      = addr_q;
      sel_d       = sel_q;
      opb_d       = opb_q;
      swap_d      = swap_q;
      sc_d        = 1'b0;
      sc_fail_d   = sc_fail_q;
      res_valid_d = res_valid_q;
      res_addr_d  = res_addr_q;
      unique case (state_q)
         Idle: begin
            in_gnt_o = in_req_i;
            amo_d    = AmoNone;
            if (is_amo || is_lr) out_wen_o = 1'b0;
            if (is_sc) begin
               out_wen_o = 1'b1;
               out_req_o = in_req_i & sc_ok;
            end
            if (in_req_i) begin
               sel_d = sel;
               if (is_amo) begin
                  state_d = DoAmo;
                  amo_d   = in_amo_i;
                  addr_d  = in_add_i;
                  opb_d   = opb;
                  swap_d  = swp;
               end
               if (is_lr) begin
                  res_valid_d[in_id_i] = 1'b1;
                  res_addr_d[in_id_i]  = in_add_i;
               end
               if (is_sc) begin
                  sc_d                 = 1'b1;
                  sc_fail_d            = !sc_ok;
                  res_valid_d[in_id_i] = 1'b0;
               end
               // Any write to the row kills every reservation on it.
               if (is_amo || (is_plain && in_wen_i) || (is_sc && sc_ok)) begin
                  for (int i = 0; i < int'(NumIds); i++) begin
                     if (res_addr_q[i] == in_add_i) res_valid_d[i] = 1'b0;
                  end
               end
            end
         end
         DoAmo: begin
            out_req_o   = 1'b1;
            out_wen_o   = 1'b1;
            out_add_o   = addr_q;
            out_be_o    = '0;
            out_wdata_o = '0;
            for (int l = 0; l < NumLanes; l++) begin
               if (sel_q == LaneW'(l)) begin
                  out_be_o[4*l +: 4]     = 4'hF;
                  out_wdata_o[32*l +: 32] = result;
               end
            end
            amo_d   = AmoNone;
            state_d = Idle;
         end
         default: state_d = Idle;
      endcase
   end

   assign rvalid_d = in_gnt_o;

   always_comb begin
      in_rdata_o = out_rdata_i;
      if (state_q == DoAmo) begin
         in_rdata_o = '0;
         for (int l = 0; l < NumLanes; l++) begin
            if (sel_q == LaneW'(l)) in_rdata_o[32*l +: 32] = old;
         end
      end else if (sc_q) begin
         in_rdata_o = '0;
         for (int l = 0; l < NumLanes; l++) begin
            if (sel_q == LaneW'(l)) in_rdata_o[32*l +: 32] = {31'b0, sc_fail_q};
         end
      end
   end

   assign in_rvalid_o = rvalid_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= Idle;
         amo_q       <= AmoNone;
         addr_q      <= '0;
         sel_q       <= '0;
         opb_q       <= '0;
         swap_q      <= '0;
         rvalid_q    <= 1'b0;
         sc_q        <= 1'b0;
         sc_fail_q   <= 1'b0;
         res_valid_q <= '0;
         for (int i = 0; i < int'(NumIds); i++) res_addr_q[i] <= '0;
      end else begin
         state_q     <= state_d;
         amo_q       <= amo_d;
         addr_q      <= addr_d;
         sel_q       <= sel_d;
         opb_q       <= opb_d;
         swap_q      <= swap_d;
         rvalid_q    <= rvalid_d;
         sc_q        <= sc_d;
         sc_fail_q   <= sc_fail_d;
         res_valid_q <= res_valid_d;
         for (int i = 0; i < int'(NumIds); i++) res_addr_q[i] <= res_addr_d[i];
      end
   end

endmodule

// File: tb/tb_amo_shim_lrsc.sv
// Directed bench for amo_shim_lrsc with a 1-cycle-latency SRAM stub.
// Expected values are hand-computed constants.
module tb_amo_shim_lrsc;

   logic        clk_i = 1'b0;
   logic        rst_ni;
   logic        in_req_i;
   logic        in_gnt_o;
   logic [31:0] in_add_i;
   logic [3:0]  in_amo_i;
   logic        in_wen_i;
   logic [63:0] in_wdata_i;
   logic [7:0]  in_be_i;
   logic [2:0]  in_id_i;
   logic [63:0] in_rdata_o;
   logic        in_rvalid_o;
   logic        out_req_o;
   logic [31:0] out_add_o;
   logic        out_wen_o;
   logic [63:0] out_wdata_o;
   logic [7:0]  out_be_o;
   logic [63:0] out_rdata_i;

   logic [63:0] mem [16];

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk_i = ~clk_i;

   amo_shim_lrsc dut (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .in_req_i   (in_req_i),
      .in_gnt_o   (in_gnt_o),
      .in_add_i   (in_add_i),
      .in_amo_i   (in_amo_i),
      .in_wen_i   (in_wen_i),
      .in_wdata_i (in_wdata_i),
      .in_be_i    (in_be_i),
      .in_id_i    (in_id_i),
      .in_rdata_o (in_rdata_o),
      .in_rvalid_o(in_rvalid_o),
      .out_req_o  (out_req_o),
      .out_add_o  (out_add_o),
      .out_wen_o  (out_wen_o),
      .out_wdata_o(out_wdata_o),
      .out_be_o   (out_be_o),
      .out_rdata_i(out_rdata_i)
   );

   always @(posedge clk_i) begin
      if (out_req_o) begin
         if (out_wen_o) begin
            for (int b = 0; b < 8; b++)
               if (out_be_o[b]) mem[out_add_o[3:0]][8*b +: 8] <= out_wdata_o[8*b +: 8];
         end else begin
            out_rdata_i <= mem[out_add_o[3:0]];
         end
      end
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic xact(input string tag, input logic [3:0] amo, input logic wen,
                       input logic [31:0] add, input logic [63:0] wd,
                       input logic [7:0] be, input logic [2:0] id,
                       output logic [63:0] rd, output logic oreq);
      bit got = 1'b0;
      @(posedge clk_i); #1;
      in_req_i = 1'b1; in_amo_i = amo; in_wen_i = wen; in_add_i = add;
      in_wdata_i = wd; in_be_i = be; in_id_i = id;
      for (int k = 0; k < 8 && !got; k++) begin
         @(negedge clk_i);
         if (in_gnt_o) got = 1'b1;
         else begin @(posedge clk_i); #1; end
      end
      oreq = out_req_o;
      if (!got) check({tag, "_gnt_timeout"}, 64'd0, 64'd1);
      @(posedge clk_i); #1;
      in_req_i = 1'b0;
      @(negedge clk_i);
      check({tag, "_rvalid"}, 64'(in_rvalid_o), 64'd1);
      rd = in_rdata_o;
   endtask

   logic [63:0] rd;
   logic        oq;

   initial begin
      rst_ni = 1'b0; in_req_i = 1'b1; in_amo_i = 4'h0; in_wen_i = 1'b0;
      in_add_i = 32'h3; in_wdata_i = '0; in_be_i = 8'hFF; in_id_i = '0;
      #2;
      check("rst_rvalid", 64'(in_rvalid_o), 64'd0);
      check("rst_gnt_ft", 64'(in_gnt_o), 64'd1);
      check("rst_req_ft", 64'(out_req_o), 64'd1);
      check("rst_add_ft", 64'(out_add_o), 64'h3);
      in_req_i = 1'b0;
      #1;
      check("rst_gnt_low", 64'(in_gnt_o), 64'd0);
      repeat (2) @(posedge clk_i);
      #1 rst_ni = 1'b1;

      // AMO add on upper lane
      xact("st5", 4'h0, 1'b1, 5, 64'h0000_0003_0000_0007, 8'hFF, 0, rd, oq);
      xact("add5", 4'h2, 1'b0, 5, 64'h0000_0002_0000_0000, 8'hF0, 0, rd, oq);
      check("add5_rdata", rd, 64'h0000_0003_0000_0000);
      xact("ld5", 4'h0, 1'b0, 5, 64'h0, 8'hFF, 0, rd, oq);
      check("ld5_mem", rd, 64'h0000_0005_0000_0007);

      // min / minu / add wrap
      xact("st6a", 4'h0, 1'b1, 6, 64'h0000_0000_FFFF_FFFF, 8'hFF, 0, rd, oq);
      xact("min6", 4'h8, 1'b0, 6, 64'h1, 8'h0F, 0, rd, oq);
      check("min6_rdata", rd, 64'h0000_0000_FFFF_FFFF);
      xact("ld6a", 4'h0, 1'b0, 6, 64'h0, 8'hFF, 0, rd, oq);
      check("min6_mem", rd, 64'h0000_0000_FFFF_FFFF);
      xact("minu6", 4'h9, 1'b0, 6, 64'h1, 8'h0F, 0, rd, oq);
      check("minu6_rdata", rd, 64'h0000_0000_FFFF_FFFF);
      xact("ld6b", 4'h0, 1'b0, 6, 64'h0, 8'hFF, 0, rd, oq);
      check("minu6_mem", rd, 64'h1);
      xact("st6b", 4'h0, 1'b1, 6, 64'h0000_0000_FFFF_FFFF, 8'hFF, 0, rd, oq);
      xact("addw6", 4'h2, 1'b0, 6, 64'h1, 8'h0F, 0, rd, oq);
      check("addw6_rdata", rd, 64'h0000_0000_FFFF_FFFF);
      xact("ld6c", 4'h0, 1'b0, 6, 64'h0, 8'hFF, 0, rd, oq);
      check("addw6_mem", rd, 64'h0);

      // swap / maxu / max / or / and / xor chain on lane 0
      xact("st7", 4'h0, 1'b1, 7, 64'h0000_000F_0000_00F0, 8'hFF, 0, rd, oq);
      xact("swap7", 4'h1, 1'b0, 7, 64'h8000_0001, 8'h0F, 0, rd, oq);
      check("swap7_rdata", rd, 64'h0000_00F0);
      xact("maxu7", 4'h7, 1'b0, 7, 64'h1, 8'h0F, 0, rd, oq);
      check("maxu7_rdata", rd, 64'h8000_0001);
      xact("max7", 4'h6, 1'b0, 7, 64'h1, 8'h0F, 0, rd, oq);
      check("max7_rdata", rd, 64'h8000_0001);
      xact("or7", 4'h4, 1'b0, 7, 64'h0F00, 8'h0F, 0, rd, oq);
      check("or7_rdata", rd, 64'h1);
      xact("and7", 4'h3, 1'b0, 7, 64'h0FF0, 8'h0F, 0, rd, oq);
      check("and7_rdata", rd, 64'h0F01);
      xact("xor7", 4'h5, 1'b0, 7, 64'h00FF, 8'h0F, 0, rd, oq);
      check("xor7_rdata", rd, 64'h0F00);
      xact("ld7", 4'h0, 1'b0, 7, 64'h0, 8'hFF, 0, rd, oq);
      check("chain7_mem", rd, 64'h0000_000F_0000_0FFF);

      // CAS hit and miss
      xact("st8a", 4'h0, 1'b1, 8, 64'h7, 8'hFF, 0, rd, oq);
      xact("cas8a", 4'hA, 1'b0, 8, 64'h0000_0009_0000_0007, 8'h0F, 0, rd, oq);
      check("cas_hit_rdata", rd, 64'h7);
      xact("ld8a", 4'h0, 1'b0, 8, 64'h0, 8'hFF, 0, rd, oq);
      check("cas_hit_mem", rd, 64'h9);
      xact("st8b", 4'h0, 1'b1, 8, 64'h7, 8'hFF, 0, rd, oq);
      xact("cas8b", 4'hA, 1'b0, 8, 64'h0000_0009_0000_0006, 8'h0F, 0, rd, oq);
      check("cas_miss_rdata", rd, 64'h7);
      xact("ld8b", 4'h0, 1'b0, 8, 64'h0, 8'hFF, 0, rd, oq);
      check("cas_miss_mem", rd, 64'h7);

      // LR/SC success then repeat failure
      xact("st4", 4'h0, 1'b1, 4, 64'h1111_2222_3333_4444, 8'hFF, 0, rd, oq);
      xact("lr2", 4'hB, 1'b0, 4, 64'h0, 8'hFF, 2, rd, oq);
      check("lr2_rdata", rd, 64'h1111_2222_3333_4444);
      xact("sc2a", 4'hC, 1'b0, 4, 64'h0000_AAAA_0000_BBBB, 8'hFF, 2, rd, oq);
      check("sc2a_rdata", rd, 64'h0);
      check("sc2a_req", 64'(oq), 64'd1);
      xact("ld4a", 4'h0, 1'b0, 4, 64'h0, 8'hFF, 0, rd, oq);
      check("sc2a_mem", rd, 64'h0000_AAAA_0000_BBBB);
      xact("sc2b", 4'hC, 1'b0, 4, 64'h5555_5555_5555_5555, 8'hFF, 2, rd, oq);
      check("sc2b_rdata", rd, 64'h1);
      check("sc2b_req", 64'(oq), 64'd0);
      xact("ld4b", 4'h0, 1'b0, 4, 64'h0, 8'hFF, 0, rd, oq);
      check("sc2b_mem", rd, 64'h0000_AAAA_0000_BBBB);

      // Foreign store kills reservation; foreign load does not
      xact("lr1a", 4'hB, 1'b0, 4, 64'h0, 8'hFF, 1, rd, oq);
      xact("st3", 4'h0, 1'b1, 4, 64'h0C0C, 8'hFF, 3, rd, oq);
      xact("sc1a", 4'hC, 1'b0, 4, 64'hDEAD, 8'hFF, 1, rd, oq);
      check("sc1a_rdata", rd, 64'h1);
      check("sc1a_req", 64'(oq), 64'd0);
      xact("ld4c", 4'h0, 1'b0, 4, 64'h0, 8'hFF, 0, rd, oq);
      check("sc1a_mem", rd, 64'h0C0C);
      xact("lr1b", 4'hB, 1'b0, 4, 64'h0, 8'hFF, 1, rd, oq);
      xact("ld3", 4'h0, 1'b0, 4, 64'h0, 8'hFF, 3, rd, oq);
      check("ld3_rdata", rd, 64'h0C0C);
      xact("sc1b", 4'hC, 1'b0, 4, 64'hBEEF, 8'hFF, 1, rd, oq);
      check("sc1b_rdata", rd, 64'h0);
      check("sc1b_req", 64'(oq), 64'd1);
      xact("ld4d", 4'h0, 1'b0, 4, 64'h0, 8'hFF, 0, rd, oq);
      check("sc1b_mem", rd, 64'hBEEF);
      xact("sc1c", 4'hC, 1'b0, 4, 64'h0, 8'hF0, 1, rd, oq);
      check("sc_fail_hilane", rd, 64'h0000_0001_0000_0000);

      // AMO on a row kills its reservation; other rows untouched
      xact("st12", 4'h0, 1'b1, 12, 64'h0, 8'hFF, 0, rd, oq);
      xact("lr6", 4'hB, 1'b0, 12, 64'h0, 8'hFF, 6, rd, oq);
      xact("lr4", 4'hB, 1'b0, 13, 64'h0, 8'hFF, 4, rd, oq);
      xact("amo12", 4'h2, 1'b0, 12, 64'h1, 8'h0F, 0, rd, oq);
      xact("sc6", 4'hC, 1'b0, 12, 64'h0, 8'hFF, 6, rd, oq);
      check("sc6_after_amo", rd, 64'h1);
      xact("sc4", 4'hC, 1'b0, 13, 64'h0, 8'hFF, 4, rd, oq);
      check("sc4_other_row", rd, 64'h0);

      // Back-to-back: AMO then load held high
      xact("st9", 4'h0, 1'b1, 9, 64'h10, 8'hFF, 0, rd, oq);
      @(posedge clk_i); #1;
      in_req_i = 1'b1; in_amo_i = 4'h2; in_wen_i = 1'b0; in_add_i = 9;
      in_wdata_i = 64'h1; in_be_i = 8'h0F; in_id_i = 0;
      @(negedge clk_i);
      check("b2b_gnt_c1", 64'(in_gnt_o), 64'd1);
      @(posedge clk_i); #1;
      in_amo_i = 4'h0; in_be_i = 8'hFF; in_wdata_i = 64'h0;
      @(negedge clk_i);
      check("b2b_gnt_c2", 64'(in_gnt_o), 64'd0);
      check("b2b_rvalid_c2", 64'(in_rvalid_o), 64'd1);
      check("b2b_rdata_c2", in_rdata_o, 64'h10);
      check("b2b_wen_c2", 64'(out_wen_o), 64'd1);
      check("b2b_wdata_c2", out_wdata_o, 64'h11);
      check("b2b_be_c2", 64'(out_be_o), 64'h0F);
      @(posedge clk_i); #1;
      @(negedge clk_i);
      check("b2b_gnt_c3", 64'(in_gnt_o), 64'd1);
      check("b2b_rvalid_c3", 64'(in_rvalid_o), 64'd0);
      @(posedge clk_i); #1;
      in_req_i = 1'b0;
      @(negedge clk_i);
      check("b2b_rvalid_c4", 64'(in_rvalid_o), 64'd1);
      check("b2b_rdata_c4", in_rdata_o, 64'h11);

      // Reset during DoAMO aborts the write and drops reservations
      xact("st10", 4'h0, 1'b1, 10, 64'h22, 8'hFF, 0, rd, oq);
      xact("st11", 4'h0, 1'b1, 11, 64'h0, 8'hFF, 0, rd, oq);
      xact("lr5", 4'hB, 1'b0, 11, 64'h0, 8'hFF, 5, rd, oq);
      @(posedge clk_i); #1;
      in_req_i = 1'b1; in_amo_i = 4'h2; in_wen_i = 1'b0; in_add_i = 10;
      in_wdata_i = 64'h1; in_be_i = 8'h0F; in_id_i = 0;
      @(negedge clk_i);
      check("rstamo_gnt", 64'(in_gnt_o), 64'd1);
      @(posedge clk_i); #1;
      in_req_i = 1'b0;
      rst_ni   = 1'b0;
      @(negedge clk_i);
      check("rstamo_rvalid", 64'(in_rvalid_o), 64'd0);
      check("rstamo_req", 64'(out_req_o), 64'd0);
      @(posedge clk_i); #1;
      rst_ni = 1'b1;
      xact("ld10", 4'h0, 1'b0, 10, 64'h0, 8'hFF, 0, rd, oq);
      check("rstamo_mem", rd, 64'h22);
      xact("sc5", 4'hC, 1'b0, 11, 64'h0, 8'hFF, 5, rd, oq);
      check("sc5_after_rst", rd, 64'h1);
      check("sc5_req", 64'(oq), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/amo_shim_lrsc.md
# amo_shim_lrsc

Parametrised atomic shim for one TCDM bank: executes RISC-V A-extension AMOs on a selected 32-bit lane of a DataWidth-bit SRAM word and adds LR/SC via a per-requester reservation table. Sits between the bank-side interconnect port and a single-port SRAM with 1-cycle read latency, with exclusive access to that SRAM. Adds an explicit response-valid strobe.

## Interface
- AddrMemWidth, 32, bank row address width
- DataWidth, 64, SRAM word width; multiple of 32, ≥32
- NumIds, 8, requesters tracked for reservations; IdWidth = max(1, $clog2(NumIds)) derived
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous reset, active-low
- in_req_i  in  1  request
- in_gnt_o  out  1  grant
- in_add_i  in  AddrMemWidth  row address
- in_amo_i  in  4  op: 0 none, 1 swap, 2 add, 3 and, 4 or, 5 xor, 6 max, 7 maxu, 8 min, 9 minu, A cas, B lr, C sc, D-F = none
- in_wen_i  in  1  1 store, 0 load (ops 0/D-F only)
- in_wdata_i  in  DataWidth  write data / operand
- in_be_i  in  DataWidth/8  byte enable
- in_id_i  in  IdWidth  requester id
- in_rdata_o  out  DataWidth  response data
- in_rvalid_o  out  1  response valid, 1 cycle after grant
- out_req_o, out_add_o, out_wen_o, out_wdata_o, out_be_o  out  1/AddrMemWidth/1/DataWidth/DataWidth/8  SRAM port
- out_rdata_i  in  DataWidth  SRAM read data, valid 1 cycle after read req

## Operation
- Lane sel = lowest 4-byte group of in_be_i with any bit set (lane 0 if be = 0). Operand b = in_wdata_i lane sel; CAS swap value = lane (sel+1) mod NumLanes (degenerates to same lane for DataWidth 32).
- FSM Idle / DoAMO. Idle: feed-through of req/add/wen/wdata/be; in_gnt_o = in_req_i.
- AMO 1-A granted in Idle: SRAM read issued that cycle; register op, addr, sel, operands; go DoAMO.
- DoAMO (1 cycle): in_gnt_o = 0; out_req_o = 1, out_wen_o = 1, out_add_o = addr_q, out_be_o = 4'hF at lane sel, out_wdata_o = result at lane sel, 0 elsewhere; in_rdata_o = old lane value at sel, 0 elsewhere; return to Idle.
- ALU 32-bit: add wraps mod 2^32; min/max via 33-bit subtract, signed ops sign-extend, unsigned zero-extend; CAS writes swap value if old == b, else old value.
- LR (B): plain read of in_add_i; reservation[id] <= {valid, in_add_i}; full word returned.
- SC (C): success iff reservation[id] valid and addr == in_add_i. Success: write passes through, response lane sel = 0. Failure: out_req_o = 0, still granted, response lane sel = 1. Reservation[id] cleared either way.
- Granularity = SRAM row. Any granted store, AMO, or successful SC clears every reservation whose addr equals in_add_i (at grant). Loads/LR never clear others. Repeated LR of same id overwrites.
- Ops D-F: plain access per in_wen_i.

## Timing
- Reset: state Idle, all reservations invalid, in_rvalid_o = 0, internal op = none; other outputs are feed-through (out_req_o = in_req_i).
- in_rvalid_o = 1 exactly one cycle after every grant (load, store, AMO, LR, SC). Load/LR data = out_rdata_i passthrough; store response data don't-care; AMO data as in DoAMO; SC data from registered result.
- AMO occupancy 2 cycles: grant cycle, DoAMO cycle (no grant); next request grantable cycle after DoAMO. Non-AMO: one per cycle.
- AMO write and response in same cycle (DoAMO).
- Requester holds in_req_i and all inputs until in_gnt_o.
- Reset mid-DoAMO: write aborted, returns to Idle, no in_rvalid_o.

## Test plan
- DataWidth 64: mem[5] = 0x0000_0003_0000_0007; amo add, be 0xF0, wdata hi 2 -> rvalid with rdata 0x0000_0003_0000_0000, mem[5] = 0x0000_0005_0000_0007, gnt low in DoAMO.
- min/minu on 0xFFFF_FFFF vs 1: min writes 0xFFFF_FFFF, minu writes 1; add 0xFFFF_FFFF+1 writes 0.
- CAS lane 0 old 7, wdata {9,7} -> writes 9, returns 7; wdata {9,6} -> mem unchanged, returns 7.
- LR id 2 row 4, SC id 2 row 4 -> write done, rdata 0; second SC -> fails, rdata 1, no SRAM req.
- LR id 1 row 4, store id 3 row 4, SC id 1 -> fails; LR id 1 row 4, load id 3 row 4, SC id 1 -> succeeds.
- Back-to-back: AMO then load held high -> load granted cycle 3, rvalid every granted cycle +1; reset asserted in DoAMO -> no write, rvalid 0.
